// File: rtl/mem_resp_sel.sv
// rtl/mem_resp_sel.sv - in-order merge of cache and LSU responses for the MEM stage
//
// Keeps a FIFO of route tags ({cache, load}) in the order the MEM stage
// issued its requests. Only the source named by the oldest tag may hand over
// a beat, so both paths merge into one in-order response stream. A one-entry
// output register holds each response until the pipeline takes it.
//
// Optional build macro: MEM_RESP_BYPASS_EN
//   When defined, a head response that arrives while the output register is
//   empty and resp_ready_i=1 goes straight to resp_* in the same cycle.
//   Otherwise every response passes through the output register, so it
//   appears one cycle after the source handshake.
//
// Parameters:
//   DEPTH           maximum outstanding requests (power of two, >= 2)
// Ports:
//   clk, rstn_i     clock, asynchronous active-low reset
//   req_*           request log: valid, cache(1)/lsu(0), load(1)/store(0), ready (= !full)
//   cache_*         cache response: rvalid, rdata, err, rready
//   lsu_*           LSU response: rvalid, rdata, err, rready
//   resp_*          merged response: valid, data, load, err (00 ok, 01 bus, 10 protocol), ready

module mem_resp_sel #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn_i,

    input  logic        req_valid_i,
    input  logic        req_cache_i,
    input  logic        req_load_i,
    output logic        req_ready_o,

    input  logic        cache_rvalid_i,
    input  logic [31:0] cache_rdata_i,
    input  logic        cache_err_i,
    output logic        cache_rready_o,

    input  logic        lsu_rvalid_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        lsu_err_i,
    output logic        lsu_rready_o,

    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_load_o,
    output logic [1:0]  resp_err_o,
    input  logic        resp_ready_i
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_PROTO = 2'b10;

    // ------------------------------------------------------------------
    // Route-tag FIFO
    // ------------------------------------------------------------------
    logic [1:0]  tag_mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A push is refused while full even if the head pops in the same cycle.
    assign req_ready_o = !full;
    assign push        = req_valid_i && !full;

    logic head_cache;
    logic head_load;

    assign head_cache = tag_mem[rptr[AW-1:0]][1];
    assign head_load  = tag_mem[rptr[AW-1:0]][0];

    // ------------------------------------------------------------------
    // Output register state
    // ------------------------------------------------------------------
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_load;
    logic [1:0]  out_err;

    // ------------------------------------------------------------------
    // Timeout tracking for a head source that never answers
    // ------------------------------------------------------------------
    logic [7:0] to_cnt;
    logic       to_fired;

    // ------------------------------------------------------------------
    // Source selection and accept logic
    // ------------------------------------------------------------------
    logic        head_rvalid;
    logic [31:0] head_rdata;
    logic        head_err;
    logic        other_rvalid;
    logic        can_load;
    logic        accept;
    logic        stray;
    logic        timeout_err;
    logic        proto_err;
    logic        load_en;
    logic        bypass;

    assign head_rvalid  = head_cache ? cache_rvalid_i : lsu_rvalid_i;
    assign head_rdata   = head_cache ? cache_rdata_i  : lsu_rdata_i;
    assign head_err     = head_cache ? cache_err_i    : lsu_err_i;
    assign other_rvalid = head_cache ? lsu_rvalid_i   : cache_rvalid_i;

    // The output register can take a new beat when empty or draining now.
    assign can_load = !out_valid || resp_ready_i;

    assign accept = !empty && head_rvalid && can_load;

    // A beat with nothing outstanding cannot belong to any request.
    assign stray = empty && (cache_rvalid_i || lsu_rvalid_i) && can_load;

    // The non-head source is talking while the head source has been silent
    // for 256 cycles (counter saturated at 255 plus this cycle). Reported
    // once per head entry; the non-head beat itself is left at its source.
    assign timeout_err = !empty && !head_rvalid && other_rvalid &&
                         (to_cnt == 8'hFF) && !to_fired && can_load;

    assign proto_err = stray || timeout_err;
    assign load_en   = accept || proto_err;
    assign pop       = accept;

    // rready is gated by reset so that both stay low while rstn_i is low,
    // even though an empty FIFO would otherwise treat any beat as stray.
    always_comb begin
        cache_rready_o = 1'b0;
        lsu_rready_o   = 1'b0;
        if (rstn_i) begin
            if (accept) begin
                if (head_cache) begin
                    cache_rready_o = 1'b1;
                end else begin
                    lsu_rready_o = 1'b1;
                end
            end else if (stray) begin
                // Cache beat is drained first; an LSU stray is taken next cycle.
                if (cache_rvalid_i) begin
                    cache_rready_o = 1'b1;
                end else begin
                    lsu_rready_o = 1'b1;
                end
            end
        end
    end

    // Response contents for whatever is loaded this cycle.
    logic [31:0] nxt_data;
    logic        nxt_load;
    logic [1:0]  nxt_err;

    always_comb begin
        nxt_data = 32'd0;
        nxt_load = 1'b0;
        nxt_err  = ERR_PROTO;
        if (accept) begin
            nxt_data = head_load ? head_rdata : 32'd0;
            nxt_load = head_load;
            nxt_err  = {1'b0, head_err};
        end
    end

`ifdef MEM_RESP_BYPASS_EN
    // Same-cycle delivery when nothing is parked in the output register.
    assign bypass = load_en && !out_valid && resp_ready_i;

    assign resp_valid_o = out_valid || bypass;
    assign resp_data_o  = bypass ? nxt_data : out_data;
    assign resp_load_o  = bypass ? nxt_load : out_load;
    assign resp_err_o   = bypass ? nxt_err  : out_err;
`else
    assign bypass = 1'b0;

    assign resp_valid_o = out_valid;
    assign resp_data_o  = out_data;
    assign resp_load_o  = out_load;
    assign resp_err_o   = out_err;
`endif

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wptr[AW-1:0]] <= {req_cache_i, req_load_i};
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt   <= 8'd0;
            to_fired <= 1'b0;
        end else if (pop) begin
            to_cnt   <= 8'd0;
            to_fired <= 1'b0;
        end else begin
            if (!empty && (to_cnt != 8'hFF)) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (timeout_err) begin
                to_fired <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_load  <= 1'b0;
            out_err   <= ERR_OK;
        end else if (load_en && !bypass) begin
            out_valid <= 1'b1;
            out_data  <= nxt_data;
            out_load  <= nxt_load;
            out_err   <= nxt_err;
        end else if (resp_ready_i) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_resp_sel.sv
// tb/tb_mem_resp_sel.sv - directed scoreboard bench for mem_resp_sel

module tb_mem_resp_sel;

    typedef struct packed {
        logic [31:0] data;
        logic        load;
        logic [1:0]  err;
    } exp_t;

    logic        clk;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_cache_i;
    logic        req_load_i;
    logic        req_ready_o;
    logic        cache_rvalid_i;
    logic [31:0] cache_rdata_i;
    logic        cache_err_i;
    logic        cache_rready_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic        lsu_err_i;
    logic        lsu_rready_o;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_load_o;
    logic [1:0]  resp_err_o;
    logic        resp_ready_i;

    int   total;
    int   bad;
    exp_t exp_q [$];

    mem_resp_sel #(.DEPTH(4)) dut (
        .clk            (clk),
        .rstn_i         (rstn_i),
        .req_valid_i    (req_valid_i),
        .req_cache_i    (req_cache_i),
        .req_load_i     (req_load_i),
        .req_ready_o    (req_ready_o),
        .cache_rvalid_i (cache_rvalid_i),
        .cache_rdata_i  (cache_rdata_i),
        .cache_err_i    (cache_err_i),
        .cache_rready_o (cache_rready_o),
        .lsu_rvalid_i   (lsu_rvalid_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .lsu_err_i      (lsu_err_i),
        .lsu_rready_o   (lsu_rready_o),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_load_o    (resp_load_o),
        .resp_err_o     (resp_err_o),
        .resp_ready_i   (resp_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_resp(input logic [31:0] d, input logic l, input logic [1:0] e);
        exp_t x;
        x.data = d;
        x.load = l;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic push_req(input logic c, input logic l);
        req_valid_i = 1'b1;
        req_cache_i = c;
        req_load_i  = l;
        tick();
        req_valid_i = 1'b0;
    endtask

    // Each completed output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (rstn_i && resp_valid_o && resp_ready_i) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_resp observed=%0h expected=none",
                       {resp_data_o, resp_load_o, resp_err_o});
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                assert ({resp_data_o, resp_load_o, resp_err_o} === e) else begin
                    bad++;
                    $error("FAIL resp observed=%0h expected=%0h",
                           {resp_data_o, resp_load_o, resp_err_o}, e);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rstn_i = 1'b0;
        req_valid_i = 1'b0;
        req_cache_i = 1'b0;
        req_load_i  = 1'b0;
        cache_rvalid_i = 1'b0;
        cache_rdata_i  = 32'd0;
        cache_err_i    = 1'b0;
        lsu_rvalid_i   = 1'b0;
        lsu_rdata_i    = 32'd0;
        lsu_err_i      = 1'b0;
        resp_ready_i   = 1'b1;

        // Reset state
        #3;
        check("rst_valid",   resp_valid_o,   0);
        check("rst_data",    resp_data_o,    0);
        check("rst_load",    resp_load_o,    0);
        check("rst_err",     resp_err_o,     0);
        check("rst_req_rdy", req_ready_o,    1);
        check("rst_c_rdy",   cache_rready_o, 0);
        check("rst_l_rdy",   lsu_rready_o,   0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();

        // Out-of-order LSU beat stalls behind the cache head
        push_req(1'b1, 1'b1);
        push_req(1'b0, 1'b1);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'hB;
        #1;
        check("ooo_lsu_hold0", lsu_rready_o, 0);
        tick();
        check("ooo_lsu_hold1", lsu_rready_o, 0);
        check("ooo_no_resp",   resp_valid_o, 0);
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'hA;
        expect_resp(32'hA, 1'b1, 2'b00);
        #1;
        check("ooo_c_rdy",     cache_rready_o, 1);
        check("ooo_lsu_hold2", lsu_rready_o,   0);
        tick();
        cache_rvalid_i = 1'b0;
        expect_resp(32'hB, 1'b1, 2'b00);
        #1;
        check("ooo_lsu_rdy", lsu_rready_o, 1);
        tick();
        lsu_rvalid_i = 1'b0;
        tick();
        tick();

        // Full FIFO: push with a simultaneous pop is still refused
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 1'b1);
        end
        check("full_rdy0", req_ready_o, 0);
        req_valid_i    = 1'b1;
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'h11;
        expect_resp(32'h11, 1'b1, 2'b00);
        #1;
        check("full_rdy_pp", req_ready_o, 0);
        tick();
        req_valid_i = 1'b0;
        check("full_rdy_after_pop", req_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            cache_rdata_i = 32'h12 + i;
            expect_resp(32'h12 + i, 1'b1, 2'b00);
            tick();
        end
        cache_rvalid_i = 1'b0;
        tick();
        tick();

        // Stray beat on an empty FIFO
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'h55;
        expect_resp(32'h0, 1'b0, 2'b10);
        #1;
        check("stray_c_rdy", cache_rready_o, 1);
        tick();
        cache_rvalid_i = 1'b0;
        tick();

        // LSU store with bus error; also shows the stray left no tag behind
        push_req(1'b0, 1'b0);
        lsu_rvalid_i = 1'b1;
        lsu_err_i    = 1'b1;
        lsu_rdata_i  = 32'hDEAD;
        expect_resp(32'h0, 1'b0, 2'b01);
        #1;
        check("st_err_l_rdy", lsu_rready_o, 1);
        tick();
        lsu_rvalid_i = 1'b0;
        lsu_err_i    = 1'b0;
        tick();
        tick();

        // Backpressure: first response held stable, second stalls at source
        resp_ready_i = 1'b0;
        push_req(1'b1, 1'b1);
        push_req(1'b1, 1'b1);
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'h21;
        expect_resp(32'h21, 1'b1, 2'b00);
        #1;
        check("bp_c_rdy_first", cache_rready_o, 1);
        tick();
        cache_rdata_i = 32'h22;
        expect_resp(32'h22, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", resp_valid_o,   1);
            check("bp_hold_data",  resp_data_o,    32'h21);
            check("bp_hold_rdy",   cache_rready_o, 0);
            tick();
        end
        resp_ready_i = 1'b1;
        #1;
        check("bp_release_rdy", cache_rready_o, 1);
        tick();
        cache_rvalid_i = 1'b0;
        check("bp_b2b_valid", resp_valid_o, 1);
        check("bp_b2b_data",  resp_data_o,  32'h22);
        tick();
        tick();

        // Timeout: LSU talks while the cache head stays silent
        push_req(1'b1, 1'b1);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h66;
        expect_resp(32'h0, 1'b0, 2'b10);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        check("to_l_rdy", lsu_rready_o, 0);
        lsu_rvalid_i   = 1'b0;
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'h99;
        expect_resp(32'h99, 1'b1, 2'b00);
        tick();
        cache_rvalid_i = 1'b0;
        tick();
        tick();

        // Asynchronous reset with work outstanding
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 1'b1);
        end
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'h31;
        tick();
        cache_rvalid_i = 1'b0;
        check("mid_pre_valid", resp_valid_o, 1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("mid_rst_valid",   resp_valid_o,   0);
        check("mid_rst_data",    resp_data_o,    0);
        check("mid_rst_err",     resp_err_o,     0);
        check("mid_rst_req_rdy", req_ready_o,    1);
        check("mid_rst_c_rdy",   cache_rready_o, 0);
        tick();
        rstn_i = 1'b1;
        tick();
        check("post_rst_req_rdy", req_ready_o, 1);
        resp_ready_i   = 1'b1;
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = 32'h77;
        expect_resp(32'h0, 1'b0, 2'b10);
        #1;
        check("post_rst_stray_rdy", cache_rready_o, 1);
        tick();
        cache_rvalid_i = 1'b0;
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
